multicycle_controller: RTL and testbench

Multi-cycle control unit for the MIPS subset datapath. It replaces per-instruction combinational decode with a state machine that sequences fetch, decode, execute, memory and write-back, one instruction at a time. It adds a ready/request handshake to a shared instruction/data memory and a parametrised multiply latency. It sits between the IR/PC/memory/register-file datapath and a single unified memory port.

---
 rtl/multicycle_controller_pkg.sv | 121 ++++++++++++
 rtl/multicycle_controller_if.sv | 49 ++++
 rtl/multicycle_controller_decoder.sv | 123 ++++++++++++
 rtl/multicycle_controller.sv | 142 ++++++++++++++
 tb/tb_multicycle_controller.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller_pkg                                    |
// | Description : Shared encodings for the multi-cycle MIPS control unit:      |
// |               opcodes, funct codes, ALU/branch/size codes, FSM states,     |
// |               instruction classes and the static-control bundle.           |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_MULWAIT = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM     = 4'd5,
    S_WB      = 4'd6,
    S_BRANCH  = 4'd7,
    S_JUMP    = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP    = 4'd0,
    CL_ALU    = 4'd1,
    CL_MUL    = 4'd2,
    CL_LOAD   = 4'd3,
    CL_STORE  = 4'd4,
    CL_BRANCH = 4'd5,
    CL_J      = 4'd6,
    CL_JAL    = 4'd7,
    CL_JR     = 4'd8
  } iclass_t;

  // Opcodes
  localparam logic [5:0] c_op_rtype  = 6'h00;
  localparam logic [5:0] c_op_regimm = 6'h01;
  localparam logic [5:0] c_op_j      = 6'h02;
  localparam logic [5:0] c_op_jal    = 6'h03;
  localparam logic [5:0] c_op_beq    = 6'h04;
  localparam logic [5:0] c_op_bne    = 6'h05;
  localparam logic [5:0] c_op_blez   = 6'h06;
  localparam logic [5:0] c_op_bgtz   = 6'h07;
  localparam logic [5:0] c_op_addi   = 6'h08;
  localparam logic [5:0] c_op_addiu  = 6'h09;
  localparam logic [5:0] c_op_slti   = 6'h0a;
  localparam logic [5:0] c_op_andi   = 6'h0c;
  localparam logic [5:0] c_op_ori    = 6'h0d;
  localparam logic [5:0] c_op_xori   = 6'h0e;
  localparam logic [5:0] c_op_lb     = 6'h20;
  localparam logic [5:0] c_op_lh     = 6'h21;
  localparam logic [5:0] c_op_lw     = 6'h23;
  localparam logic [5:0] c_op_sb     = 6'h28;
  localparam logic [5:0] c_op_sh     = 6'h29;
  localparam logic [5:0] c_op_sw     = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] c_fn_sll  = 6'h00;
  localparam logic [5:0] c_fn_srl  = 6'h02;
  localparam logic [5:0] c_fn_jr   = 6'h08;
  localparam logic [5:0] c_fn_mul  = 6'h18;
  localparam logic [5:0] c_fn_add  = 6'h20;
  localparam logic [5:0] c_fn_addu = 6'h21;
  localparam logic [5:0] c_fn_sub  = 6'h22;
  localparam logic [5:0] c_fn_subu = 6'h23;
  localparam logic [5:0] c_fn_and  = 6'h24;
  localparam logic [5:0] c_fn_or   = 6'h25;
  localparam logic [5:0] c_fn_xor  = 6'h26;
  localparam logic [5:0] c_fn_nor  = 6'h27;
  localparam logic [5:0] c_fn_slt  = 6'h2a;

  // ALU operations
  localparam logic [3:0] c_alu_and = 4'b0000;
  localparam logic [3:0] c_alu_or  = 4'b0001;
  localparam logic [3:0] c_alu_add = 4'b0010;
  localparam logic [3:0] c_alu_xor = 4'b0011;
  localparam logic [3:0] c_alu_nor = 4'b0100;
  localparam logic [3:0] c_alu_sll = 4'b0101;
  localparam logic [3:0] c_alu_sub = 4'b0110;
  localparam logic [3:0] c_alu_slt = 4'b0111;
  localparam logic [3:0] c_alu_srl = 4'b1000;
  localparam logic [3:0] c_alu_mul = 4'b1001;

  // Branch types
  localparam logic [2:0] c_br_beq  = 3'b000;
  localparam logic [2:0] c_br_bne  = 3'b001;
  localparam logic [2:0] c_br_bgtz = 3'b010;
  localparam logic [2:0] c_br_blez = 3'b011;
  localparam logic [2:0] c_br_bltz = 3'b100;
  localparam logic [2:0] c_br_bgez = 3'b101;

  // Memory access sizes
  localparam logic [1:0] c_size_word = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_byte = 2'b10;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src;
    logic [3:0] alu_control;
    logic       ext_op;
    logic [1:0] mem_size;
    logic       mem_sign;
    logic [2:0] branch_type;
  } ctrl_t;

  localparam ctrl_t c_ctrl_default = '{
    reg_dst:     2'b00,
    mem_to_reg:  2'b00,
    alu_src:     2'b00,
    alu_control: c_alu_add,
    ext_op:      1'b1,
    mem_size:    c_size_word,
    mem_sign:    1'b1,
    branch_type: c_br_beq
  };

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller_if                                     |
// | Description : Bundle between the control unit (master) and the datapath / |
// |               unified memory port (slave).                                 |
// | Ports       : instr, branch_cond, mem_ready  -> controller                 |
// |               memory strobes, PC/IR/regfile strobes, static controls,      |
// |               debug state                    <- controller                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface multicycle_controller_if;
  import multicycle_controller_pkg::*;

  logic [31:0] instr;
  logic        branch_cond;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic [1:0]  alu_src;
  logic [3:0]  alu_control;
  logic        ext_op;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [2:0]  branch_type;
  state_t      state;

  modport master (
    input  instr, branch_cond, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst, mem_to_reg, alu_src, alu_control, ext_op, mem_size,
           mem_sign, branch_type, state
  );

  modport slave (
    output instr, branch_cond, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst, mem_to_reg, alu_src, alu_control, ext_op, mem_size,
           mem_sign, branch_type, state
  );

endinterface
`default_nettype wire

// File: rtl/multicycle_controller_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller_decoder                                |
// | Description : Purely combinational instruction decoder. Maps the IR to    |
// |               the static datapath controls and an instruction class.      |
// |               Unsupported encodings yield class NOP with default controls.|
// | Ports       : i_instr  in  32  instruction register contents              |
// |               o_ctrl   out     static control bundle                      |
// |               o_class  out  4  instruction class                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module multicycle_controller_decoder
  import multicycle_controller_pkg::*;
(
  input  wire logic [31:0] i_instr,
  output ctrl_t            o_ctrl,
  output iclass_t          o_class
);

  logic [5:0] w_op;
  logic [4:0] w_rt;
  logic [5:0] w_funct;
  logic       w_unused_bits;

  assign w_op          = i_instr[31:26];
  assign w_rt          = i_instr[20:16];
  assign w_funct       = i_instr[5:0];
  // rs, rd, shamt and the immediate are datapath concerns only
  assign w_unused_bits = ^{i_instr[25:21], i_instr[15:6]};

  always_comb begin
    o_ctrl  = c_ctrl_default;
    o_class = CL_NOP;
    case (w_op)
      c_op_rtype: begin
        o_class            = CL_ALU;
        o_ctrl.reg_dst     = 2'b01;
        case (w_funct)
          c_fn_add, c_fn_addu: o_ctrl.alu_control = c_alu_add;
          c_fn_sub, c_fn_subu: o_ctrl.alu_control = c_alu_sub;
          c_fn_and:            o_ctrl.alu_control = c_alu_and;
          c_fn_or:             o_ctrl.alu_control = c_alu_or;
          c_fn_xor:            o_ctrl.alu_control = c_alu_xor;
          c_fn_nor:            o_ctrl.alu_control = c_alu_nor;
          c_fn_slt:            o_ctrl.alu_control = c_alu_slt;
          c_fn_sll: begin
            o_ctrl.alu_control = c_alu_sll;
            o_ctrl.alu_src     = 2'b10;
          end
          c_fn_srl: begin
            o_ctrl.alu_control = c_alu_srl;
            o_ctrl.alu_src     = 2'b10;
          end
          c_fn_mul: begin
            o_class            = CL_MUL;
            o_ctrl.alu_control = c_alu_mul;
          end
          c_fn_jr: begin
            o_class = CL_JR;
            o_ctrl  = c_ctrl_default;
          end
          default: begin
            o_class = CL_NOP;
            o_ctrl  = c_ctrl_default;
          end
        endcase
      end
      c_op_addi, c_op_addiu, c_op_slti, c_op_andi, c_op_ori, c_op_xori: begin
        o_class        = CL_ALU;
        o_ctrl.alu_src = 2'b01;
        case (w_op)
          c_op_slti: o_ctrl.alu_control = c_alu_slt;
          c_op_andi: begin o_ctrl.alu_control = c_alu_and; o_ctrl.ext_op = 1'b0; end
          c_op_ori:  begin o_ctrl.alu_control = c_alu_or;  o_ctrl.ext_op = 1'b0; end
          c_op_xori: begin o_ctrl.alu_control = c_alu_xor; o_ctrl.ext_op = 1'b0; end
          default:   o_ctrl.alu_control = c_alu_add;
        endcase
      end
      c_op_lw, c_op_lh, c_op_lb: begin
        o_class           = CL_LOAD;
        o_ctrl.alu_src    = 2'b01;
        o_ctrl.mem_to_reg = 2'b01;
        o_ctrl.mem_size   = (w_op == c_op_lw) ? c_size_word :
                            (w_op == c_op_lh) ? c_size_half : c_size_byte;
      end
      c_op_sw, c_op_sh, c_op_sb: begin
        o_class         = CL_STORE;
        o_ctrl.alu_src  = 2'b01;
        o_ctrl.mem_size = (w_op == c_op_sw) ? c_size_word :
                          (w_op == c_op_sh) ? c_size_half : c_size_byte;
      end
      c_op_beq, c_op_bne, c_op_blez, c_op_bgtz: begin
        o_class            = CL_BRANCH;
        o_ctrl.alu_control = c_alu_sub;
        o_ctrl.branch_type = (w_op == c_op_beq)  ? c_br_beq  :
                             (w_op == c_op_bne)  ? c_br_bne  :
                             (w_op == c_op_blez) ? c_br_blez : c_br_bgtz;
      end
      c_op_regimm: begin
        // Only bltz (rt=0) and bgez (rt=1) are supported under REGIMM
        if (w_rt == 5'd0) begin
          o_class            = CL_BRANCH;
          o_ctrl.branch_type = c_br_bltz;
        end else if (w_rt == 5'd1) begin
          o_class            = CL_BRANCH;
          o_ctrl.branch_type = c_br_bgez;
        end
      end
      c_op_j:   o_class = CL_J;
      c_op_jal: begin
        o_class           = CL_JAL;
        o_ctrl.reg_dst    = 2'b10;
        o_ctrl.mem_to_reg = 2'b10;
      end
      default: begin
        o_class = CL_NOP;
        o_ctrl  = c_ctrl_default;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller                                        |
// | Description : Multi-cycle control FSM for the MIPS subset datapath.        |
// |               Sequences fetch/decode/execute/memory/write-back with a     |
// |               ready/request handshake to a unified memory and a           |
// |               parametrised multiply latency.                              |
// | Ports       : clk    in   system clock                                    |
// |               reset  in   synchronous active-high reset                   |
// |               bus    master modport of multicycle_controller_if           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  wire logic               clk,
  input  wire logic               reset,
  multicycle_controller_if.master bus
);

  localparam logic [3:0] c_mul_load = 4'(MUL_CYCLES - 1);

  state_t     r_state;
  iclass_t    r_class;
  ctrl_t      r_ctrl;
  logic [3:0] r_mul_cnt;

  ctrl_t      w_dec_ctrl;
  iclass_t    w_dec_class;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_reg_write;

  multicycle_controller_decoder u_decoder (
    .i_instr (bus.instr),
    .o_ctrl  (w_dec_ctrl),
    .o_class (w_dec_class)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_class   <= CL_NOP;
      r_ctrl    <= c_ctrl_default;
      r_mul_cnt <= 4'd0;
    end else begin
      case (r_state)
        S_FETCH: if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_ctrl  <= w_dec_ctrl;
          r_class <= w_dec_class;
          case (w_dec_class)
            CL_ALU:               r_state <= S_EXEC;
            CL_MUL: begin
              r_state   <= S_MULWAIT;
              r_mul_cnt <= c_mul_load;
            end
            CL_LOAD, CL_STORE:    r_state <= S_ADDR;
            CL_BRANCH:            r_state <= S_BRANCH;
            CL_J, CL_JAL, CL_JR:  r_state <= S_JUMP;
            default:              r_state <= S_FETCH;
          endcase
        end
        S_EXEC: r_state <= S_WB;
        S_MULWAIT: begin
          if (r_mul_cnt == 4'd0) r_state <= S_WB;
          else                   r_mul_cnt <= r_mul_cnt - 4'd1;
        end
        S_ADDR: r_state <= S_MEM;
        S_MEM: begin
          if (bus.mem_ready) r_state <= (r_class == CL_LOAD) ? S_WB : S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes are forced low while reset is held so an aborted instruction
  // never leaves a partial PC or register-file write behind.
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_iord      = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_src    = 2'b00;
    w_reg_write = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          w_mem_req = 1'b1;
          if (bus.mem_ready) begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
          end
        end
        S_MEM: begin
          w_mem_req = 1'b1;
          w_iord    = 1'b1;
          w_mem_we  = (r_class == CL_STORE);
        end
        S_WB: w_reg_write = 1'b1;
        S_BRANCH: begin
          w_pc_src   = 2'b01;
          w_pc_write = bus.branch_cond;
        end
        S_JUMP: begin
          w_pc_write  = 1'b1;
          w_pc_src    = (r_class == CL_JR) ? 2'b11 : 2'b10;
          w_reg_write = (r_class == CL_JAL);
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_we      = w_mem_we;
  assign bus.iord        = w_iord;
  assign bus.ir_write    = w_ir_write;
  assign bus.pc_write    = w_pc_write;
  assign bus.pc_src      = w_pc_src;
  assign bus.reg_write   = w_reg_write;
  assign bus.reg_dst     = r_ctrl.reg_dst;
  assign bus.mem_to_reg  = r_ctrl.mem_to_reg;
  assign bus.alu_src     = r_ctrl.alu_src;
  assign bus.alu_control = r_ctrl.alu_control;
  assign bus.ext_op      = r_ctrl.ext_op;
  assign bus.mem_size    = r_ctrl.mem_size;
  assign bus.mem_sign    = r_ctrl.mem_sign;
  assign bus.branch_type = r_ctrl.branch_type;
  assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_controller                                     |
// | Description : Directed self-checking bench for multicycle_controller.      |
// |               Two instances (MUL_CYCLES=4 and 1) share all inputs.         |
// | Ports       : none                                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_multicycle_controller;

  localparam logic [31:0] c_add  = 32'h0022_1820; // add  $3,$1,$2
  localparam logic [31:0] c_lw   = 32'h8C25_0008; // lw   $5,8($1)
  localparam logic [31:0] c_sw   = 32'hAC25_0004; // sw   $5,4($1)
  localparam logic [31:0] c_mul  = 32'h0022_2018; // mul  $4,$1,$2
  localparam logic [31:0] c_beq  = 32'h1022_0004; // beq  $1,$2,+4
  localparam logic [31:0] c_bltz = 32'h0420_0004; // bltz $1,+4
  localparam logic [31:0] c_rgi2 = 32'h0422_0004; // REGIMM rt=2 (unsupported)
  localparam logic [31:0] c_jal  = 32'h0C00_0010; // jal
  localparam logic [31:0] c_jr   = 32'h03E0_0008; // jr   $31

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller_if bus4 ();
  multicycle_controller_if bus1 ();

  assign bus1.instr       = bus4.instr;
  assign bus1.mem_ready   = bus4.mem_ready;
  assign bus1.branch_cond = bus4.branch_cond;

  multicycle_controller #(.MUL_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.master));
  multicycle_controller #(.MUL_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive handshake inputs for this cycle, then check {state, req, we, ir, pc, rw}
  task automatic step(input string tag, input logic rdy, input logic bc,
                      input logic [3:0] st, input logic [4:0] strb);
    bus4.mem_ready   = rdy;
    bus4.branch_cond = bc;
    #1;
    chk(tag, {23'd0, bus4.state, bus4.mem_req, bus4.mem_we, bus4.ir_write,
              bus4.pc_write, bus4.reg_write}, {23'd0, st, strb});
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus4.instr = 32'd0;
    bus4.mem_ready = 1'b1;
    bus4.branch_cond = 1'b0;
    nx(); nx();

    // Reset state
    step("reset", 1'b1, 1'b0, 4'd0, 5'b00000);
    chk("rst_alu", 32'(bus4.alu_control), 32'h2);
    chk("rst_ext", 32'(bus4.ext_op), 32'h1);
    chk("rst_sign", 32'(bus4.mem_sign), 32'h1);
    chk("rst_regdst", 32'(bus4.reg_dst), 32'h0);

    // add: FETCH, DECODE, EXEC, WB
    reset = 1'b0;
    bus4.instr = c_add;
    step("add_f", 1'b1, 1'b0, 4'd0, 5'b10110);
    chk("add_f_iord", 32'(bus4.iord), 32'h0);
    chk("add_f_pcsrc", 32'(bus4.pc_src), 32'h0);
    nx();
    step("add_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("add_e", 1'b1, 1'b0, 4'd2, 5'b00000);
    chk("add_regdst", 32'(bus4.reg_dst), 32'h1);
    chk("add_alu", 32'(bus4.alu_control), 32'h2);
    nx();
    step("add_wb", 1'b1, 1'b0, 4'd6, 5'b00001); nx();

    // lw with two stall cycles in MEM
    bus4.instr = c_lw;
    step("lw_f", 1'b1, 1'b0, 4'd0, 5'b10110); nx();
    step("lw_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("lw_a", 1'b1, 1'b0, 4'd4, 5'b00000);
    chk("lw_alusrc", 32'(bus4.alu_src), 32'h1);
    nx();
    step("lw_m1", 1'b0, 1'b0, 4'd5, 5'b10000);
    chk("lw_m1_iord", 32'(bus4.iord), 32'h1);
    nx();
    step("lw_m2", 1'b0, 1'b0, 4'd5, 5'b10000); nx();
    step("lw_m3", 1'b1, 1'b0, 4'd5, 5'b10000);
    chk("lw_m3_iord", 32'(bus4.iord), 32'h1);
    nx();
    step("lw_wb", 1'b1, 1'b0, 4'd6, 5'b00001);
    chk("lw_memtoreg", 32'(bus4.mem_to_reg), 32'h1);
    nx();

    // sw: MEM drives MemWe, then straight back to FETCH
    bus4.instr = c_sw;
    step("sw_f", 1'b1, 1'b0, 4'd0, 5'b10110); nx();
    step("sw_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("sw_a", 1'b1, 1'b0, 4'd4, 5'b00000); nx();
    step("sw_m", 1'b1, 1'b0, 4'd5, 5'b11000); nx();

    // mul: 4 MULWAIT cycles on dut4, 1 on dut1
    bus4.instr = c_mul;
    step("mul_f", 1'b1, 1'b0, 4'd0, 5'b10110); nx();
    step("mul_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("mul_w1", 1'b1, 1'b0, 4'd3, 5'b00000);
    chk("mul1_w1_state", 32'(bus1.state), 32'h3);
    nx();
    step("mul_w2", 1'b1, 1'b0, 4'd3, 5'b00000);
    chk("mul1_wb_state", 32'(bus1.state), 32'h6);
    chk("mul1_wb_rw", 32'(bus1.reg_write), 32'h1);
    chk("mul1_wb_alu", 32'(bus1.alu_control), 32'h9);
    nx();
    step("mul_w3", 1'b1, 1'b0, 4'd3, 5'b00000); nx();
    step("mul_w4", 1'b1, 1'b0, 4'd3, 5'b00000); nx();
    step("mul_wb", 1'b1, 1'b0, 4'd6, 5'b00001);
    chk("mul_wb_alu", 32'(bus4.alu_control), 32'h9);
    nx();

    // realign both instances
    reset = 1'b1; nx(); reset = 1'b0;

    // beq not taken / taken, bltz taken, REGIMM rt=2 as NOP
    bus4.instr = c_beq;
    step("beq0_f", 1'b1, 1'b0, 4'd0, 5'b10110); nx();
    step("beq0_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("beq0_b", 1'b1, 1'b0, 4'd7, 5'b00000);
    chk("beq_btype", 32'(bus4.branch_type), 32'h0);
    nx();
    step("beq1_f", 1'b1, 1'b0, 4'd0, 5'b10110); nx();
    step("beq1_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("beq1_b", 1'b1, 1'b1, 4'd7, 5'b00010);
    chk("beq1_pcsrc", 32'(bus4.pc_src), 32'h1);
    nx();
    bus4.instr = c_bltz;
    step("bltz_f", 1'b1, 1'b0, 4'd0, 5'b10110); nx();
    step("bltz_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("bltz_b", 1'b1, 1'b1, 4'd7, 5'b00010);
    chk("bltz_btype", 32'(bus4.branch_type), 32'h4);
    nx();
    bus4.instr = c_rgi2;
    step("rgi2_f", 1'b1, 1'b0, 4'd0, 5'b10110); nx();
    step("rgi2_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("rgi2_back", 1'b1, 1'b0, 4'd0, 5'b10110);
    bus4.instr = c_jal;
    nx();

    // jal (fetched by the cycle above), then jr
    step("jal_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("jal_j", 1'b1, 1'b0, 4'd8, 5'b00011);
    chk("jal_pcsrc", 32'(bus4.pc_src), 32'h2);
    chk("jal_regdst", 32'(bus4.reg_dst), 32'h2);
    chk("jal_memtoreg", 32'(bus4.mem_to_reg), 32'h2);
    nx();
    bus4.instr = c_jr;
    step("jr_f", 1'b1, 1'b0, 4'd0, 5'b10110); nx();
    step("jr_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("jr_j", 1'b1, 1'b0, 4'd8, 5'b00010);
    chk("jr_pcsrc", 32'(bus4.pc_src), 32'h3);
    nx();

    // Reset during MULWAIT
    bus4.instr = c_mul;
    step("rmw_f", 1'b1, 1'b0, 4'd0, 5'b10110); nx();
    step("rmw_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("rmw_w", 1'b1, 1'b0, 4'd3, 5'b00000); nx();
    reset = 1'b1;
    step("rmw_hold", 1'b1, 1'b0, 4'd3, 5'b00000); nx();
    step("rmw_rst", 1'b1, 1'b0, 4'd0, 5'b00000);
    chk("rmw_alu", 32'(bus4.alu_control), 32'h2);
    chk("rmw_regdst", 32'(bus4.reg_dst), 32'h0);
    reset = 1'b0;
    bus4.instr = c_lw;
    step("rmw_req", 1'b1, 1'b0, 4'd0, 5'b10110); nx();

    // Reset during a MEM stall
    step("rmem_d", 1'b1, 1'b0, 4'd1, 5'b00000); nx();
    step("rmem_a", 1'b1, 1'b0, 4'd4, 5'b00000); nx();
    step("rmem_m", 1'b0, 1'b0, 4'd5, 5'b10000); nx();
    reset = 1'b1;
    step("rmem_hold", 1'b1, 1'b0, 4'd5, 5'b00000); nx();
    step("rmem_rst", 1'b1, 1'b0, 4'd0, 5'b00000);
    chk("rmem_memtoreg", 32'(bus4.mem_to_reg), 32'h0);
    chk("rmem_alusrc", 32'(bus4.alu_src), 32'h0);
    reset = 1'b0;
    step("rmem_req", 1'b1, 1'b0, 4'd0, 5'b10110); nx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
